// File: rtl/change_dispenser_if.sv
// Bundle of request, coin-ejector handshake and status signals for the change dispenser.
// Coin handshake: coin_out is a transfer when coin_out_valid and dispense_ack are both high on a
// rising edge; while valid is high and ack is low, coin_out is held stable.
interface change_dispenser_if;
    logic        start;
    logic [15:0] paid;
    logic [15:0] price;
    logic        refill;
    logic        dispense_ack;
    logic [1:0]  coin_out;
    logic        coin_out_valid;
    logic        busy;
    logic        done;
    logic        change_error;
    logic [15:0] remaining;
    logic [3:0]  stock_500;
    logic [3:0]  stock_1000;
    logic [3:0]  stock_2000;
    logic [3:0]  stock_5000;

    modport master (
        output start, paid, price, refill, dispense_ack,
        input  coin_out, coin_out_valid, busy, done, change_error, remaining,
        input  stock_500, stock_1000, stock_2000, stock_5000
    );

    modport slave (
        input  start, paid, price, refill, dispense_ack,
        output coin_out, coin_out_valid, busy, done, change_error, remaining,
        output stock_500, stock_1000, stock_2000, stock_5000
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: computes paid - price and ejects coins largest-first from finite
// per-denomination stocks, one coin per ejector handshake.
module change_dispenser #(
    parameter logic [3:0] STOCK_INIT = 4'd10,
    parameter logic [3:0] STOCK_FULL = 4'd15
) (
    input  logic                clk,
    input  logic                reset,
    change_dispenser_if.slave   bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {IDLE, CALC, SELECT, WAIT_ACK, FINISH} state_e;

    state_e           state_q, state_d;
    logic [15:0]      paid_q, paid_d, price_q, price_d;
    logic [15:0]      remaining_q, remaining_d;
    logic [3:0][3:0]  stock_q, stock_d;      // indexed by coin code
    logic [1:0]       coin_q, coin_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d, busy_q, busy_d;
    logic             done_q, done_d, cerr_q, cerr_d;
    logic             found;
    logic [1:0]       pick;

    function automatic logic [15:0] coin_value(input logic [1:0] c);
        case (c)
            2'd0:    return 16'd500;
            2'd1:    return 16'd1000;
            2'd2:    return 16'd2000;
            default: return 16'd5000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        paid_d      = paid_q;
        price_d     = price_q;
        remaining_d = remaining_q;
        stock_d     = stock_q;
        coin_d      = coin_q;
        err_d       = err_q;
        found       = 1'b0;
        pick        = 2'd0;

        // Largest denomination that fits and is in stock; an empty stock is never picked.
        for (int i = 3; i >= 0; i--) begin
            if (!found && stock_q[i] != 4'd0 && coin_value(2'(i)) <= remaining_q) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.refill) stock_d = {4{STOCK_FULL}};
                if (bus.start) begin
                    paid_d  = bus.paid;
                    price_d = bus.price;
                    err_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (price_q > paid_q) begin
                    err_d       = 1'b1;
                    remaining_d = 16'd0;
                    state_d     = FINISH;
                end else begin
                    remaining_d = paid_q - price_q;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q == 16'd0) begin
                    state_d = FINISH;
                end else if (found) begin
                    coin_d  = pick;
                    state_d = WAIT_ACK;
                end else begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            WAIT_ACK: begin
                if (bus.dispense_ack) begin
                    stock_d[coin_q] = stock_q[coin_q] - 4'd1;
                    remaining_d     = remaining_q - coin_value(coin_q);
                    state_d         = SELECT;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs follow the next state so they line up with the state register.
        valid_d = (state_d == WAIT_ACK);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
        cerr_d  = (state_d == FINISH) && err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            paid_q      <= 16'd0;
            price_q     <= 16'd0;
            remaining_q <= 16'd0;
            stock_q     <= {4{STOCK_INIT}};
            coin_q      <= 2'd0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            paid_q      <= paid_d;
            price_q     <= price_d;
            remaining_q <= remaining_d;
            stock_q     <= stock_d;
            coin_q      <= coin_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cerr_q      <= cerr_d;
        end
    end

    assign bus.coin_out       = coin_q;
    assign bus.coin_out_valid = valid_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.change_error   = cerr_q;
    assign bus.remaining      = remaining_q;
    assign bus.stock_500      = stock_q[0];
    assign bus.stock_1000     = stock_q[1];
    assign bus.stock_2000     = stock_q[2];
    assign bus.stock_5000     = stock_q[3];
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table of payouts plus hand-written corner sequences
// (slow ack, stock exhaustion, refill, reset during a coin handshake).
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    change_dispenser_if bus();

    change_dispenser dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     paid;
        logic [15:0]     price;
        int              n_coins;
        logic [3:0][1:0] coins;     // coins[0] is the first coin expected
        bit              err;
        logic [15:0]     rem;
        int              done_cyc;  // 0: latency not checked
    } vec_t;

    vec_t       vecs[7];
    logic [1:0] exp_q[$];
    int         mstock[4];
    int         n_vec;
    int         n_miscmp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] get_stock(input int idx);
        case (idx)
            0:       return bus.stock_500;
            1:       return bus.stock_1000;
            2:       return bus.stock_2000;
            default: return bus.stock_5000;
        endcase
    endfunction

    task automatic check_stocks(input string tag);
        check({tag, "_stock_500"},  32'(bus.stock_500),  32'(mstock[0]));
        check({tag, "_stock_1000"}, 32'(bus.stock_1000), 32'(mstock[1]));
        check({tag, "_stock_2000"}, 32'(bus.stock_2000), 32'(mstock[2]));
        check({tag, "_stock_5000"}, 32'(bus.stock_5000), 32'(mstock[3]));
    endtask

    task automatic set_model_stocks(input int v);
        for (int i = 0; i < 4; i++) mstock[i] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coin_out"},     32'(bus.coin_out),       0);
        check({tag, "_valid"},        32'(bus.coin_out_valid), 0);
        check({tag, "_busy"},         32'(bus.busy),           0);
        check({tag, "_done"},         32'(bus.done),           0);
        check({tag, "_change_error"}, 32'(bus.change_error),   0);
        check({tag, "_remaining"},    32'(bus.remaining),      0);
        check({tag, "_state"},        32'(dbg_state),          0);
        set_model_stocks(10);
        check_stocks(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Drives one request and plays the ejector; expected coins must already be in exp_q.
    task automatic payout(input logic [15:0] p_paid, input logic [15:0] p_price,
                          input int ack_delay, input bit ack_hold, input bit with_refill,
                          input bit poke, input bit exp_err, input logic [15:0] exp_rem,
                          input int done_cyc);
        int         cyc;
        int         wait_n;
        bit         seen_done;
        logic [1:0] held;
        logic [1:0] e;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.paid         = p_paid;
        bus.price        = p_price;
        bus.refill       = with_refill;
        bus.dispense_ack = ack_hold;
        @(negedge clk);
        cyc = 0; wait_n = 0; seen_done = 0; held = 2'd0;
        while (!seen_done && cyc < 300) begin
            cyc++;
            bus.start  = 1'b0;
            bus.refill = 1'b0;
            if (bus.done) begin
                seen_done = 1;
                check("change_error", 32'(bus.change_error), 32'(exp_err));
                check("remaining",    32'(bus.remaining),    32'(exp_rem));
                check("coins_left",   32'(exp_q.size()),     0);
                if (done_cyc != 0) check("done_latency", 32'(cyc), 32'(done_cyc));
                bus.dispense_ack = 1'b0;
            end else if (bus.coin_out_valid) begin
                if (wait_n == 0) held = bus.coin_out;
                else begin
                    check("coin_stable",   32'(bus.coin_out),        32'(held));
                    check("stock_no_dec",  32'(get_stock(int'(held))), 32'(mstock[int'(held)]));
                end
                if (wait_n >= ack_delay) begin
                    bus.dispense_ack = 1'b1;
                    check("coin_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("coin_out", 32'(bus.coin_out), 32'(e));
                        mstock[int'(e)]--;
                    end
                    wait_n = 0;
                end else begin
                    bus.dispense_ack = ack_hold;
                    if (poke) begin
                        bus.start  = 1'b1;
                        bus.paid   = 16'd9999;
                        bus.price  = 16'd0;
                        bus.refill = 1'b1;
                    end
                    wait_n++;
                end
            end else begin
                bus.dispense_ack = ack_hold;
            end
            if (!seen_done) @(negedge clk);
        end
        check("done_seen", 32'(seen_done), 1);
        @(negedge clk);
        bus.dispense_ack = 1'b0;
        check("done_pulse_low", 32'(bus.done), 0);
        check("busy_idle",      32'(bus.busy), 0);
        check_stocks("payout");
    endtask

    initial begin
        n_vec = 0; n_miscmp = 0;
        bus.start = 1'b0; bus.paid = 16'd0; bus.price = 16'd0;
        bus.refill = 1'b0; bus.dispense_ack = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // coins packed with the first coin in the rightmost slot
        vecs[0] = '{16'd8000,  16'd1500, 3, {2'd0, 2'd0, 2'd1, 2'd3}, 1'b0, 16'd0,   0};
        vecs[1] = '{16'd3000,  16'd3000, 0, 8'd0,                     1'b0, 16'd0,   3};
        vecs[2] = '{16'd1000,  16'd2000, 0, 8'd0,                     1'b1, 16'd0,   2};
        vecs[3] = '{16'd10000, 16'd1200, 4, {2'd0, 2'd1, 2'd2, 2'd3}, 1'b1, 16'd300, 0};
        vecs[4] = '{16'd2000,  16'd0,    1, {2'd0, 2'd0, 2'd0, 2'd2}, 1'b0, 16'd0,   0};
        vecs[5] = '{16'd4500,  16'd1000, 3, {2'd0, 2'd0, 2'd1, 2'd2}, 1'b0, 16'd0,   0};
        vecs[6] = '{16'd600,   16'd0,    1, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b1, 16'd100, 0};

        apply_reset();

        for (int i = 0; i < 7; i++) begin
            bit hold;
            hold = (i == 4);
            for (int k = 0; k < vecs[i].n_coins; k++) exp_q.push_back(vecs[i].coins[k]);
            payout(vecs[i].paid, vecs[i].price, hold ? 0 : int'($urandom_range(0, 2)), hold,
                   1'b0, 1'b0, vecs[i].err, vecs[i].rem, vecs[i].done_cyc);
        end

        // Slow ejector: five idle cycles per coin, with start/refill pokes that must be ignored.
        exp_q.push_back(2'd1);
        payout(16'd1000, 16'd0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 0);

        // Drain the 500 stock, then one request too many.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(2'd0);
            payout(16'd500, 16'd0, int'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0);
        end
        payout(16'd500, 16'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd500, 0);

        @(negedge clk);
        bus.refill = 1'b1;
        @(negedge clk);
        bus.refill = 1'b0;
        set_model_stocks(15);
        check_stocks("refill");
        check("refill_busy", 32'(bus.busy), 0);

        exp_q.push_back(2'd3);
        payout(16'd5000, 16'd0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0);

        // Refill together with start: payout must draw from freshly refilled stocks.
        set_model_stocks(15);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd3);
        payout(16'd10000, 16'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0);

        // Reset while a coin is presented and unacknowledged.
        @(negedge clk);
        bus.start = 1'b1; bus.paid = 16'd1000; bus.price = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            int budget;
            budget = 0;
            while (!bus.coin_out_valid && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("reset_test_valid", 32'(bus.coin_out_valid), 1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        exp_q.push_back(2'd2);
        payout(16'd2500, 16'd500, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter STOCK_INIT, default 4'd10, per-denomination coin count loaded at reset.
REQ-002 Parameter STOCK_FULL, default 4'd15, per-denomination coin count loaded on refill.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a change payout; sampled only in IDLE.
REQ-006 paid  input  16  total inserted money (unsigned), sampled with start.
REQ-007 price  input  16  selected product price (unsigned), sampled with start.
REQ-008 refill  input  1  reload all coin stocks; sampled only in IDLE.
REQ-009 dispense_ack  input  1  ejector accepted the presented coin.
REQ-010 coin_out  output  2  denomination presented: 00=500, 01=1000, 10=2000, 11=5000.
REQ-011 coin_out_valid  output  1  coin_out is being presented.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of every accepted request.
REQ-014 change_error  output  1  one-cycle pulse, coincident with done, when exact change failed.
REQ-015 remaining  output  16  change still owed.
REQ-016 stock_500, stock_1000, stock_2000, stock_5000  output  4 each  coins held.

Function
REQ-017 States SHALL be IDLE, CALC, SELECT, WAIT_ACK, FINISH; all outputs SHALL be registered.
REQ-018 IDLE + start: latch paid and price, go to CALC next cycle; start outside IDLE SHALL be ignored.
REQ-019 CALC (1 cycle): price > paid -> FINISH with error flag set, remaining = 0; else remaining = paid - price (16-bit), go to SELECT.
REQ-020 SELECT: remaining = 0 -> FINISH, no error; else pick the largest denomination with value <= remaining and stock > 0, drive coin_out, go to WAIT_ACK.
REQ-021 SELECT with remaining > 0 and no eligible denomination -> FINISH with error flag set; remaining holds the unpaid amount.
REQ-022 WAIT_ACK: coin_out_valid = 1, coin_out stable until dispense_ack; on ack, decrement that stock, subtract its value from remaining, return to SELECT.
REQ-023 Selection SHALL be greedy with no backtracking; coins already issued before an error are not recovered.
REQ-024 FINISH (1 cycle): done = 1; change_error = error flag; then go to IDLE.
REQ-025 dispense_ack outside WAIT_ACK SHALL be ignored.
REQ-026 refill in IDLE sets all four stocks to STOCK_FULL; refill outside IDLE SHALL be ignored.
REQ-027 refill and start together in IDLE: both SHALL be honoured, and the payout uses the refilled stocks.
REQ-028 Stocks SHALL never underflow, since only stocks > 0 are selected.
REQ-029 remaining not a multiple of 500 SHALL end in change_error with remaining < 500.

Reset
REQ-030 reset SHALL take priority over all inputs and return the block to IDLE at the next edge.
REQ-031 Reset values: coin_out = 00; coin_out_valid, busy, done, change_error = 0; remaining = 0; all stocks = STOCK_INIT.
REQ-032 Reset mid-payout SHALL abandon the request; the stock of the presented, unacknowledged coin is not decremented.

Verification
REQ-033 After reset, start with paid=8000, price=1500, ack 1 cycle after each valid -> coins 11, 01, 00 in order; done with no error; stocks 500/1000/2000/5000 = 9/9/10/9.
REQ-034 paid=1000, price=2000 -> no coin_out_valid; done and change_error pulse 2 cycles after start; remaining = 0.
REQ-035 paid=price=3000 -> no coins; done pulses with change_error = 0; stocks unchanged.
REQ-036 ack held low 5 cycles in WAIT_ACK -> coin_out_valid high and coin_out unchanged throughout; exactly one stock decrement after ack.
REQ-037 Ten payouts of change 500, then an eleventh -> eleventh pulses change_error, remaining = 500, stock_500 = 0; then refill -> all stocks = 15.
REQ-038 reset asserted in WAIT_ACK -> next cycle all outputs at reset values; a following start is accepted normally.
